// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage and a loader/DMA port.
// Latency: request seen in IDLE at cycle 0 -> strobes at cycle 1 -> Ack at cycle MEM_LATENCY+1.
// Backpressure: one access in flight; requesters hold Req until Ack, StallM freezes the CPU meanwhile.
// Optional: define DMEM_ALIGN_CHECK_EN to add CpuErr/DmaErr and suppress misaligned memory accesses.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [1:0]  CpuType,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWData,
    output logic [31:0] CpuRData,
    output logic        CpuAck,
    output logic        StallM,
    input  logic        DmaReq,
    input  logic        DmaWrite,
    input  logic [1:0]  DmaType,
    input  logic [31:0] DmaAddr,
    input  logic [31:0] DmaWData,
    output logic [31:0] DmaRData,
    output logic        DmaAck,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        CpuErr,
    output logic        DmaErr,
`endif
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [1:0]  MemType,
    input  logic [31:0] MemRData
);

    // WAIT down-counter only needs to hold MEM_LATENCY-2.
    localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   waitCnt;
    logic [SW-1:0]   starveCnt;
    logic            reqDma;
    logic            reqWrite;
    logic            reqMis;

    logic            anyReq;
    logic            dmaWins;
    logic            winWrite;
    logic            winMis;
    logic [1:0]      winType;
    logic [31:0]     winAddr;
    logic [31:0]     winWData;
    logic            lastMemCycle;
    logic            finishCycle;

    // Pick the winner: CPU first unless the DMA has lost MAX_WAIT contested rounds in a row.
    always_comb begin
        anyReq   = CpuReq | DmaReq;
        dmaWins  = DmaReq & (~CpuReq | (starveCnt == SW'(MAX_WAIT)));
        winWrite = dmaWins ? DmaWrite : CpuWrite;
        winType  = dmaWins ? DmaType  : CpuType;
        winAddr  = dmaWins ? DmaAddr  : CpuAddr;
        winWData = dmaWins ? DmaWData : CpuWData;
`ifdef DMEM_ALIGN_CHECK_EN
        case (winType)
            2'b01:   winMis = winAddr[0];
            2'b10:   winMis = 1'b0;
            default: winMis = (winAddr[1:0] != 2'b00);
        endcase
`else
        winMis   = 1'b0;
`endif
    end

    // The edge ending lastMemCycle samples MemRData; finishCycle is the one that moves into RESP.
    always_comb begin
        lastMemCycle = ((state == ISSUE) && !reqMis && (MEM_LATENCY == 1)) ||
                       ((state == WAIT) && (waitCnt == '0));
        finishCycle  = lastMemCycle || ((state == ISSUE) && reqMis);
    end

    // Stall the pipeline for the whole CPU access, releasing it in the Ack cycle.
    assign StallM = CpuReq & ~CpuAck;

    // Access sequencer: IDLE -> ISSUE -> WAIT* -> RESP, all outputs registered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            starveCnt <= '0;
            reqDma    <= 1'b0;
            reqWrite  <= 1'b0;
            reqMis    <= 1'b0;
            MemAddr   <= '0;
            MemWData  <= '0;
            MemWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemType   <= '0;
            CpuAck    <= 1'b0;
            DmaAck    <= 1'b0;
            CpuRData  <= '0;
            DmaRData  <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            CpuErr    <= 1'b0;
            DmaErr    <= 1'b0;
`endif
        end else begin
            CpuAck <= finishCycle & ~reqDma;
            DmaAck <= finishCycle & reqDma;
`ifdef DMEM_ALIGN_CHECK_EN
            CpuErr <= finishCycle & ~reqDma & reqMis;
            DmaErr <= finishCycle & reqDma & reqMis;
`endif
            if (lastMemCycle && !reqWrite) begin
                if (reqDma) begin
                    DmaRData <= MemRData;
                end else begin
                    CpuRData <= MemRData;
                end
            end

            case (state)
                IDLE: begin
                    if (anyReq) begin
                        reqDma   <= dmaWins;
                        reqWrite <= winWrite;
                        reqMis   <= winMis;
                        MemAddr  <= winAddr;
                        MemWData <= winWData;
                        MemType  <= winType;
                        MemWrite <= winWrite & ~winMis;
                        MemRead  <= ~winWrite & ~winMis;
                        if (dmaWins) begin
                            starveCnt <= '0;
                        end else if (DmaReq) begin
                            starveCnt <= starveCnt + SW'(1);
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The write strobe is a single-cycle pulse; reads stay up until data is taken.
                    MemWrite <= 1'b0;
                    if (finishCycle) begin
                        MemRead <= 1'b0;
                        state   <= RESP;
                    end else begin
                        waitCnt <= CW'(MEM_LATENCY - 2);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (finishCycle) begin
                        MemRead <= 1'b0;
                        state   <= RESP;
                    end else begin
                        waitCnt <= waitCnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
